// File: rtl/avalon_st_pkt_arbiter_if.sv
// Avalon-ST stream bundle shared by the packet arbiter's inputs and output.
// The source drives the master side; the sink drives rdy back from the slave side.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W =
        (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic [EMPTY_W-1:0]               empty;
    logic                             valid;
    logic                             rdy;
    logic                             sop;
    logic                             eop;

    modport master (
        output data,
        output empty,
        output valid,
        output sop,
        output eop,
        input  rdy
    );

    modport slave (
        input  data,
        input  empty,
        input  valid,
        input  sop,
        input  eop,
        output rdy
    );
endinterface

// File: rtl/avalon_st_pkt_arbiter.sv
// Two-input round-robin Avalon-ST arbiter with packet-level grants,
// stray-beat discard in IDLE and per-source wrapping packet counters.
module avalon_st_pkt_arbiter #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_st_if.slave           in_a,
    avalon_st_if.slave           in_b,
    avalon_st_if.master          arb_msg,
    output logic                 grant_a,
    output logic                 grant_b,
    output logic [1:0]           drop_indi,
    output logic [CNT_WIDTH-1:0] pkt_cnt_a,
    output logic [CNT_WIDTH-1:0] pkt_cnt_b
);
    localparam int DW = DATA_WIDTH_IN_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t  state;
    state_t  state_nxt;
    logic    last_grant;
    logic    req_a;
    logic    req_b;
    logic    fire_a;
    logic    fire_b;
    logic [DW-1:0] data_mux;

    assign req_a = in_a.valid & in_a.sop;
    assign req_b = in_b.valid & in_b.sop;

    assign grant_a = (state == GRANT_A);
    assign grant_b = (state == GRANT_B);

    assign arb_msg.data = data_mux;

    always_comb begin
        state_nxt     = state;
        data_mux      = '0;
        arb_msg.empty = '0;
        arb_msg.valid = 1'b0;
        arb_msg.sop   = 1'b0;
        arb_msg.eop   = 1'b0;
        in_a.rdy      = 1'b0;
        in_b.rdy      = 1'b0;
        drop_indi     = 2'b00;
        fire_a        = 1'b0;
        fire_b        = 1'b0;

        unique case (state)
            IDLE: begin
                // Non-SOP beats between packets are swallowed here
                drop_indi[0] = in_a.valid & ~in_a.sop;
                drop_indi[1] = in_b.valid & ~in_b.sop;
                in_a.rdy     = drop_indi[0];
                in_b.rdy     = drop_indi[1];
                if (req_a && (!req_b || last_grant)) begin
                    state_nxt = GRANT_A;
                end else if (req_b) begin
                    state_nxt = GRANT_B;
                end
            end
            GRANT_A: begin
                data_mux      = in_a.data;
                arb_msg.empty = in_a.empty;
                arb_msg.valid = in_a.valid;
                arb_msg.sop   = in_a.sop;
                arb_msg.eop   = in_a.eop;
                in_a.rdy      = arb_msg.rdy;
                fire_a = in_a.valid & in_a.eop & arb_msg.rdy;
                if (fire_a) begin
                    state_nxt = IDLE;
                end
            end
            GRANT_B: begin
                data_mux      = in_b.data;
                arb_msg.empty = in_b.empty;
                arb_msg.valid = in_b.valid;
                arb_msg.sop   = in_b.sop;
                arb_msg.eop   = in_b.eop;
                in_b.rdy      = arb_msg.rdy;
                fire_b = in_b.valid & in_b.eop & arb_msg.rdy;
                if (fire_b) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Nothing is accepted or dropped while reset is held
        if (rst) begin
            in_a.rdy  = 1'b0;
            in_b.rdy  = 1'b0;
            drop_indi = 2'b00;
            fire_a    = 1'b0;
            fire_b    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            pkt_cnt_a  <= '0;
            pkt_cnt_b  <= '0;
        end else begin
            state <= state_nxt;
            if (fire_a) begin
                last_grant <= 1'b0;
                pkt_cnt_a  <= pkt_cnt_a + 1'b1;
            end
            if (fire_b) begin
                last_grant <= 1'b1;
                pkt_cnt_b  <= pkt_cnt_b + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// Directed self-checking bench for avalon_st_pkt_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_avalon_st_pkt_arbiter;
    localparam int NB = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) a_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) b_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) o_if ();

    logic          grant_a;
    logic          grant_b;
    logic [1:0]    drop_indi;
    logic [CW-1:0] pkt_cnt_a;
    logic [CW-1:0] pkt_cnt_b;

    int n_cmp = 0;
    int n_err = 0;
    int exp_a = 0;
    int exp_b = 0;
    int k;
    logic [6:0] pat;

    avalon_st_pkt_arbiter #(
        .DATA_WIDTH_IN_BYTES(NB),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_a(a_if),
        .in_b(b_if),
        .arb_msg(o_if),
        .grant_a(grant_a),
        .grant_b(grant_b),
        .drop_indi(drop_indi),
        .pkt_cnt_a(pkt_cnt_a),
        .pkt_cnt_b(pkt_cnt_b)
    );

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drv_a(input logic v, input logic s, input logic e,
                         input logic [127:0] d, input logic [3:0] emp);
        a_if.valid = v;
        a_if.sop   = s;
        a_if.eop   = e;
        a_if.data  = d;
        a_if.empty = emp;
    endtask

    task automatic drv_b(input logic v, input logic s, input logic e,
                         input logic [127:0] d, input logic [3:0] emp);
        b_if.valid = v;
        b_if.sop   = s;
        b_if.eop   = e;
        b_if.data  = d;
        b_if.empty = emp;
    endtask

    task automatic do_reset();
        drv_a(0, 0, 0, '0, 0);
        drv_b(0, 0, 0, '0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_a = 0;
        exp_b = 0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        o_if.rdy = 1'b1;
        drv_a(1, 0, 0, 128'h55, 0);
        drv_b(0, 0, 0, '0, 0);
        #3;
        chk("rst_grant_a", grant_a, 0);
        chk("rst_grant_b", grant_b, 0);
        chk("rst_drop", drop_indi, 0);
        chk("rst_valid", o_if.valid, 0);
        chk("rst_rdy_a", a_if.rdy, 0);
        chk("rst_rdy_b", b_if.rdy, 0);
        chk("rst_cnt_a", pkt_cnt_a, 0);
        chk("rst_cnt_b", pkt_cnt_b, 0);
        drv_a(0, 0, 0, '0, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 3-beat A packet
        drv_a(1, 1, 0, 128'hA0, 0);
        settle();
        chk("t1_idle_grant", grant_a, 0);
        chk("t1_idle_rdy_a", a_if.rdy, 0);
        chk("t1_idle_valid", o_if.valid, 0);
        tick();
        settle();
        chk("t1_c1_grant", grant_a, 1);
        chk("t1_c1_valid", o_if.valid, 1);
        chk("t1_c1_sop", o_if.sop, 1);
        chk("t1_c1_data", o_if.data, 128'hA0);
        chk("t1_c1_rdy_a", a_if.rdy, 1);
        chk("t1_c1_rdy_b", b_if.rdy, 0);
        tick();
        drv_a(1, 0, 0, 128'hA1, 0);
        settle();
        chk("t1_c2_data", o_if.data, 128'hA1);
        chk("t1_c2_sop", o_if.sop, 0);
        chk("t1_c2_eop", o_if.eop, 0);
        tick();
        drv_a(1, 0, 1, 128'hA2, 5);
        settle();
        chk("t1_c3_data", o_if.data, 128'hA2);
        chk("t1_c3_eop", o_if.eop, 1);
        chk("t1_c3_empty", o_if.empty, 5);
        chk("t1_c3_rdy_b", b_if.rdy, 0);
        tick();
        drv_a(0, 0, 0, '0, 0);
        settle();
        exp_a++;
        chk("t1_c4_grant", grant_a, 0);
        chk("t1_c4_valid", o_if.valid, 0);
        chk("t1_c4_cnt_a", pkt_cnt_a, exp_a);

        // Tie alternation over 8 single-beat packets
        do_reset();
        for (int p = 0; p < 8; p++) begin
            drv_a(1, 1, 1, 128'hA00 + p, 0);
            drv_b(1, 1, 1, 128'hB00 + p, 0);
            settle();
            chk("t2_idle_ga", grant_a, 0);
            chk("t2_idle_gb", grant_b, 0);
            chk("t2_idle_rdy_a", a_if.rdy, 0);
            chk("t2_idle_rdy_b", b_if.rdy, 0);
            tick();
            settle();
            if (p % 2 == 0) begin
                chk("t2_ga", grant_a, 1);
                chk("t2_gb", grant_b, 0);
                chk("t2_data", o_if.data, 128'hA00 + p);
                chk("t2_rdy_b", b_if.rdy, 0);
                exp_a++;
            end else begin
                chk("t2_ga", grant_a, 0);
                chk("t2_gb", grant_b, 1);
                chk("t2_data", o_if.data, 128'hB00 + p);
                chk("t2_rdy_a", a_if.rdy, 0);
                exp_b++;
            end
            tick();
        end
        drv_a(0, 0, 0, '0, 0);
        drv_b(0, 0, 0, '0, 0);
        settle();
        chk("t2_cnt_a", pkt_cnt_a, exp_a);
        chk("t2_cnt_b", pkt_cnt_b, exp_b);

        // 4-beat B packet under backpressure, stray beat parked on A
        drv_b(1, 1, 0, 128'hB0, 0);
        drv_a(1, 0, 0, 128'h77, 0);
        settle();
        chk("t3_idle_drop", drop_indi, 2'b01);
        chk("t3_idle_rdy_b", b_if.rdy, 0);
        tick();
        pat = 7'b1101001;
        k = 0;
        for (int c = 0; c < 7 && k < 4; c++) begin
            o_if.rdy = pat[c];
            drv_b(1, k == 0, k == 3, 128'hB0 + k, 0);
            settle();
            chk("t3_gb", grant_b, 1);
            chk("t3_data", o_if.data, 128'hB0 + k);
            chk("t3_eop", o_if.eop, k == 3);
            chk("t3_rdy_b", b_if.rdy, pat[c]);
            chk("t3_rdy_a", a_if.rdy, 0);
            chk("t3_drop", drop_indi, 0);
            if (pat[c]) k++;
            tick();
        end
        o_if.rdy = 1'b1;
        drv_b(0, 0, 0, '0, 0);
        settle();
        exp_b++;
        chk("t3_end_gb", grant_b, 0);
        chk("t3_end_drop", drop_indi, 2'b01);
        chk("t3_end_cnt_b", pkt_cnt_b, exp_b);

        // Stray beats on A in IDLE for two more cycles
        for (int c = 0; c < 2; c++) begin
            tick();
            settle();
            chk("t4_rdy_a", a_if.rdy, 1);
            chk("t4_drop", drop_indi, 2'b01);
            chk("t4_valid", o_if.valid, 0);
            chk("t4_ga", grant_a, 0);
        end
        drv_b(1, 1, 1, 128'hB9, 0);
        settle();
        chk("t4_sim_drop", drop_indi, 2'b01);
        chk("t4_sim_rdy_b", b_if.rdy, 0);
        chk("t4_sim_valid", o_if.valid, 0);
        tick();
        settle();
        chk("t4_gb", grant_b, 1);
        chk("t4_gb_rdy_a", a_if.rdy, 0);
        chk("t4_gb_drop", drop_indi, 0);
        chk("t4_gb_data", o_if.data, 128'hB9);
        exp_b++;
        tick();
        drv_a(0, 0, 0, '0, 0);
        drv_b(0, 0, 0, '0, 0);
        settle();
        chk("t4_cnt_a", pkt_cnt_a, exp_a);
        chk("t4_cnt_b", pkt_cnt_b, exp_b);

        // Reset in the middle of a B packet
        drv_b(1, 1, 0, 128'hB20, 0);
        tick();
        settle();
        chk("t5_gb", grant_b, 1);
        drv_b(1, 0, 0, 128'hB21, 0);
        tick();
        settle();
        chk("t5_mid_data", o_if.data, 128'hB21);
        #1;
        rst = 1'b1;
        #1;
        exp_a = 0;
        exp_b = 0;
        chk("t5_gb_rst", grant_b, 0);
        chk("t5_valid_rst", o_if.valid, 0);
        chk("t5_data_rst", o_if.data, 0);
        chk("t5_rdy_b_rst", b_if.rdy, 0);
        chk("t5_cnt_b_rst", pkt_cnt_b, 0);
        chk("t5_cnt_a_rst", pkt_cnt_a, 0);
        drv_a(1, 1, 1, 128'hA30, 0);
        drv_b(1, 1, 1, 128'hB30, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        settle();
        chk("t5_tie_ga", grant_a, 1);
        chk("t5_tie_data", o_if.data, 128'hA30);
        tick();
        drv_a(0, 0, 0, '0, 0);
        drv_b(0, 0, 0, '0, 0);
        settle();
        exp_a++;
        chk("t5_cnt_a", pkt_cnt_a, exp_a);

        // 17 single-beat A packets wrap the 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drv_a(1, 1, 1, 128'hC00 + i, 0);
            settle();
            chk("t6_idle", grant_a, 0);
            tick();
            settle();
            chk("t6_grant", grant_a, 1);
            tick();
        end
        drv_a(0, 0, 0, '0, 0);
        settle();
        chk("t6_wrap_cnt_a", pkt_cnt_a, 1);
        chk("t6_cnt_b", pkt_cnt_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/avalon_st_pkt_arbiter.md
# avalon_st_pkt_arbiter

Packet-aware two-input arbiter that shares a single Avalon-ST output stream between two upstream sources. Each input typically sits behind its own framing enforcer. Arbitration is round-robin at packet granularity: once a source is granted, it owns the output from its SOP beat through its EOP beat. The block also discards stray non-SOP beats between packets and keeps per-source packet counters for status registers.

## Interface
Parameters:
- DATA_WIDTH_IN_BYTES, 16, data bus width in bytes, shared by all three interfaces.
- CNT_WIDTH, 16, width of the per-source packet counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_a  avalon_st_if.slave  DATA_WIDTH_IN_BYTES*8 data  source A (data, empty, valid, rdy, sop, eop).
- in_b  avalon_st_if.slave  DATA_WIDTH_IN_BYTES*8 data  source B.
- arb_msg  avalon_st_if.master  DATA_WIDTH_IN_BYTES*8 data  arbitrated output stream.
- grant_a  output  1  high while the state is GRANT_A.
- grant_b  output  1  high while the state is GRANT_B.
- drop_indi  output  2  bit0/bit1 pulse for one cycle when a stray beat from A/B is discarded.
- pkt_cnt_a  output  CNT_WIDTH  number of completed A packets, wrapping.
- pkt_cnt_b  output  CNT_WIDTH  number of completed B packets, wrapping.

## Operation
- State machine: IDLE, GRANT_A, GRANT_B. Register last_grant (0=A, 1=B).
- IDLE:
  - arb_msg.valid=0 and all arb_msg fields are 0.
  - req_x = in_x.valid & in_x.sop.
  - If only one req is high, go to GRANT_x.
  - If both are high, grant the source not equal to last_grant.
  - No req: stay in IDLE.
- IDLE stray beats: in_x.valid & !in_x.sop → in_x.rdy=1 (the beat is consumed and discarded) and drop_indi[x]=1 for that cycle.
- IDLE SOP beats: in_x.rdy=0 for a valid SOP beat. It is held until the grant takes effect.
- GRANT_x, combinational passthrough:
  - arb_msg.{data,empty,valid,sop,eop} = in_x fields.
  - in_x.rdy = arb_msg.rdy.
  - The other input's rdy=0, so it stalls and nothing is dropped.
- GRANT_x exit: on in_x.valid & in_x.eop & arb_msg.rdy, go to IDLE, set last_grant=x, and increment pkt_cnt_x.
- A single-beat packet (sop&eop) is handled the same way: one passthrough cycle, then IDLE.
- SOP seen in GRANT_x mid-packet is passed through unmodified; framing is the upstream enforcer's job.
- Counters are modulo 2^CNT_WIDTH: all-ones + 1 = 0.
- grant_a/grant_b are decoded from state only; they are never both high.

## Timing
- Reset (rst=1, asynchronous):
  - State is IDLE and last_grant=B, so A wins the first tie.
  - pkt_cnt_a=pkt_cnt_b=0.
  - grant_a=grant_b=0, drop_indi=0, arb_msg.valid=0, in_a.rdy=in_b.rdy=0.
- Reset asserted mid-packet aborts the packet. arb_msg.valid drops immediately, with no EOP, and the counter is not incremented.
- Arbitration latency: one cycle. A SOP presented in IDLE at cycle N appears on arb_msg at cycle N+1.
- Passthrough latency in GRANT_x: 0 cycles, combinational from in_x to arb_msg and from arb_msg.rdy to in_x.rdy.
- Inter-packet gap: at least one IDLE cycle after every EOP, so back-to-back packets cost one bubble.
- Handshake: a beat transfers when valid & rdy are both high on a clock edge. Backpressure (arb_msg.rdy=0) holds all arb_msg fields stable because the grant cannot change during GRANT_x.
- Simultaneous events:
  - A stray beat on one input while the other input's SOP is granted in IDLE: the stray beat is still dropped that same cycle.
  - EOP accepted from x and a new SOP on y in the same cycle: the transition goes to IDLE, and y is granted on the next cycle.

## Test plan
- Reset, then A sends a 3-beat packet (sop, -, eop, empty=5) with rdy=1: grant_a rises at cycle 1 and the beats appear at cycles 1-3 with eop/empty=5 intact. The state is IDLE at cycle 4, pkt_cnt_a=1, and in_b.rdy=0 throughout.
- A and B both present SOP in IDLE after reset: A is granted first. After A's EOP, B is granted. On the next tie, A wins again (alternation verified over 8 packets).
- B packet of 4 beats with arb_msg.rdy toggling 1,0,0,1,…: the output holds data while rdy=0, exactly 4 transfers occur, in_b.rdy mirrors arb_msg.rdy, and pkt_cnt_b=1.
- IDLE with in_a.valid=1, sop=0 for 2 cycles: in_a.rdy=1 and drop_indi=2'b01 for both cycles, arb_msg.valid=0, and no counter change.
- Single-beat packets (sop=eop=1) on A repeated with CNT_WIDTH=4, 17 times: each packet takes 2 cycles and pkt_cnt_a wraps to 1.
- rst pulsed while GRANT_B is mid-packet: all outputs are immediately 0 and pkt_cnt_b is 0. After release, a tie grants A first.
